thread_fetch_sched: RTL and testbench

THREAD_FETCH_SCHED -- requirements
Module: thread_fetch_sched

---
 rtl/thread_fetch_sched.sv | 180 ++++++++++++++++++
 tb/tb_thread_fetch_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_fetch_sched.sv
// thread_fetch_sched
//
// Instruction-fetch scheduler for a fine-grained multithreaded core.
// Every cycle one hardware thread is chosen, its PC is presented to the
// instruction memory, and the returned word is registered into a single
// fetch slot. When no thread can be fetched the slot carries a bubble,
// which shows out_valid=0 and an all-ones (NOP) instruction.
//
// Two scheduling modes are available:
//   BARREL=0  round-robin that skips ineligible threads
//   BARREL=1  fixed-slot barrel; an ineligible slot thread becomes a bubble
//
// Ports
//   clk             clock, all state changes on its rising edge
//   reset           asynchronous active-high reset
//   imem_addr       {selected tid, fetch PC}, combinational
//   imem_data       instruction word for imem_addr, same cycle
//   stall_req       per-thread stall, the thread is skipped this cycle
//   redirect_valid  PC redirect strobe from downstream
//   redirect_tid    thread being redirected
//   redirect_pc     new PC for that thread
//   halt_valid      halt strobe
//   halt_tid        thread being halted
//   out_valid       fetch slot holds a real instruction
//   out_tid         thread ID of the fetch slot
//   out_pc          address of out_ir
//   out_ir          fetched instruction, all ones on a bubble
//   halted          sticky per-thread halt flags
//   all_halted      every thread is halted

module thread_fetch_sched #(
    parameter int NTHREADS = 4,
    parameter int TIDW     = $clog2(NTHREADS),
    parameter int AW       = 16,
    parameter int IW       = 16,
    parameter int BARREL   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [TIDW+AW-1:0]   imem_addr,
    input  logic [IW-1:0]        imem_data,
    input  logic [NTHREADS-1:0]  stall_req,
    input  logic                 redirect_valid,
    input  logic [TIDW-1:0]      redirect_tid,
    input  logic [AW-1:0]        redirect_pc,
    input  logic                 halt_valid,
    input  logic [TIDW-1:0]      halt_tid,
    output logic                 out_valid,
    output logic [TIDW-1:0]      out_tid,
    output logic [AW-1:0]        out_pc,
    output logic [IW-1:0]        out_ir,
    output logic [NTHREADS-1:0]  halted,
    output logic                 all_halted
);

    // Per-thread program counters
    logic [AW-1:0]       pc [NTHREADS];

    // Scheduling state: last fetched thread (round-robin) and slot counter (barrel)
    logic [TIDW-1:0]     last_tid;
    logic [TIDW-1:0]     slot;

    // Combinational scheduling results
    logic [NTHREADS-1:0] halt_now;
    logic [NTHREADS-1:0] eligible;
    logic [TIDW-1:0]     sel_tid;
    logic [TIDW-1:0]     scan_tid;
    logic                fetch;
    logic                bypass;
    logic [AW-1:0]       cur_pc;
    logic [AW-1:0]       fetch_pc;

    // A thread being halted this very cycle is already treated as halted,
    // so it can neither be fetched nor have its PC touched.
    always_comb begin
        halt_now = '0;
        eligible = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            halt_now[t] = halt_valid && (halt_tid == TIDW'(t));
            eligible[t] = !halted[t] && !stall_req[t] && !halt_now[t];
        end
    end

    // Thread selection. The round-robin scan walks from the farthest
    // candidate (last_tid itself) towards the nearest one (last_tid+1), so the
    // last eligible hit is the nearest and no early loop exit is needed.
    // When nothing is fetched, sel_tid still names the thread reported on
    // the bubble: the previous thread in round-robin, the slot in barrel mode.
    always_comb begin
        sel_tid  = last_tid;
        scan_tid = last_tid;
        fetch    = 1'b0;
        if (BARREL != 0) begin
            sel_tid = slot;
            fetch   = eligible[slot];
        end else begin
            for (int i = NTHREADS; i >= 1; i--) begin
                scan_tid = last_tid + TIDW'(i);
                if (eligible[scan_tid]) begin
                    sel_tid = scan_tid;
                    fetch   = 1'b1;
                end
            end
        end
    end

    // A redirect aimed at the thread being fetched this cycle is bypassed
    // straight onto the memory address instead of waiting a cycle.
    always_comb begin
        cur_pc    = pc[sel_tid];
        bypass    = redirect_valid && (redirect_tid == sel_tid);
        fetch_pc  = bypass ? redirect_pc : cur_pc;
        imem_addr = {sel_tid, fetch_pc};
    end

    assign all_halted = &halted;

    // PC update. Halted threads (including those halting now) keep their PC,
    // which also makes halt win over a simultaneous redirect. The fetched
    // thread advances past the fetch PC; any other thread may be redirected,
    // even while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NTHREADS; t++) begin
                pc[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                if (!halted[t] && !halt_now[t]) begin
                    if (fetch && (sel_tid == TIDW'(t))) begin
                        pc[t] <= fetch_pc + AW'(1);
                    end else if (redirect_valid && (redirect_tid == TIDW'(t))) begin
                        pc[t] <= redirect_pc;
                    end
                end
            end
        end
    end

    // Sticky halt flags, only cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted <= '0;
        end else begin
            halted <= halted | halt_now;
        end
    end

    // Scheduling pointers. last_tid resets to the top thread so the
    // round-robin scan begins at thread 0; the barrel slot starts at 0
    // and advances unconditionally every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_tid <= TIDW'(NTHREADS - 1);
            slot     <= '0;
        end else begin
            if (fetch) begin
                last_tid <= sel_tid;
            end
            slot <= slot + TIDW'(1);
        end
    end

    // Fetch slot register. A bubble still reports its thread and that
    // thread's current PC so downstream debug sees where the slot went.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_tid   <= '0;
            out_pc    <= '0;
            out_ir    <= '1;
        end else begin
            out_valid <= fetch;
            out_tid   <= sel_tid;
            out_pc    <= fetch ? fetch_pc : cur_pc;
            out_ir    <= fetch ? imem_data : '1;
        end
    end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// tb_thread_fetch_sched
//
// Drives a round-robin instance and a barrel instance of thread_fetch_sched
// with identical stimulus. Expected fetch-slot words are pushed into one
// queue per instance as each cycle is driven and popped after the edge.

module tb_thread_fetch_sched;

    localparam int NT = 4;
    localparam int TW = 2;
    localparam int AW = 16;
    localparam int IW = 16;

    logic            clk;
    logic            reset;
    logic [NT-1:0]   stall_req;
    logic            redirect_valid;
    logic [TW-1:0]   redirect_tid;
    logic [AW-1:0]   redirect_pc;
    logic            halt_valid;
    logic [TW-1:0]   halt_tid;

    logic [TW+AW-1:0] imem_addr_rr, imem_addr_b;
    logic [IW-1:0]    imem_data_rr, imem_data_b;
    logic             out_valid_rr, out_valid_b;
    logic [TW-1:0]    out_tid_rr, out_tid_b;
    logic [AW-1:0]    out_pc_rr, out_pc_b;
    logic [IW-1:0]    out_ir_rr, out_ir_b;
    logic [NT-1:0]    halted_rr, halted_b;
    logic             all_halted_rr, all_halted_b;

    logic [34:0]      obs_rr, obs_b;
    logic [34:0]      q_rr[$];
    logic [34:0]      q_b[$];
    logic [15:0]      m_pc_rr [NT];
    logic [15:0]      m_pc_b [NT];

    int total;
    int bad;

    // Instruction memory contents as a fixed function of {tid, pc}
    function automatic logic [15:0] mem_fn(input logic [17:0] a);
        return a[15:0] ^ {a[17:16], 14'h0} ^ 16'h2C5A;
    endfunction

    assign imem_data_rr = mem_fn(imem_addr_rr);
    assign imem_data_b  = mem_fn(imem_addr_b);
    assign obs_rr = {out_valid_rr, out_tid_rr, out_pc_rr, out_ir_rr};
    assign obs_b  = {out_valid_b, out_tid_b, out_pc_b, out_ir_b};

    thread_fetch_sched #(.NTHREADS(NT), .AW(AW), .IW(IW), .BARREL(0)) dut_rr (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr_rr), .imem_data(imem_data_rr),
        .stall_req(stall_req),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .out_valid(out_valid_rr), .out_tid(out_tid_rr), .out_pc(out_pc_rr), .out_ir(out_ir_rr),
        .halted(halted_rr), .all_halted(all_halted_rr)
    );

    thread_fetch_sched #(.NTHREADS(NT), .AW(AW), .IW(IW), .BARREL(1)) dut_b (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr_b), .imem_data(imem_data_b),
        .stall_req(stall_req),
        .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
        .halt_valid(halt_valid), .halt_tid(halt_tid),
        .out_valid(out_valid_b), .out_tid(out_tid_b), .out_pc(out_pc_b), .out_ir(out_ir_b),
        .halted(halted_b), .all_halted(all_halted_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return every stimulus input to idle
    task automatic clear_inputs();
        stall_req      = '0;
        redirect_valid = 1'b0;
        redirect_tid   = '0;
        redirect_pc    = '0;
        halt_valid     = 1'b0;
        halt_tid       = '0;
    endtask

    // Reset both instances of the reference PC model
    task automatic clear_model();
        for (int t = 0; t < NT; t++) begin
            m_pc_rr[t] = 16'h0000;
            m_pc_b[t]  = 16'h0000;
        end
    endtask

    // Expected slot for the round-robin instance: a fetch of thread t at its
    // model PC, or a bubble reporting thread t and its current PC
    task automatic push_rr(input int v, input int t);
        logic [1:0] tt;
        tt = 2'(t);
        if (v != 0) begin
            q_rr.push_back({1'b1, tt, m_pc_rr[t], mem_fn({tt, m_pc_rr[t]})});
            m_pc_rr[t] = m_pc_rr[t] + 16'd1;
        end else begin
            q_rr.push_back({1'b0, tt, m_pc_rr[t], 16'hFFFF});
        end
    endtask

    task automatic push_b(input int v, input int t);
        logic [1:0] tt;
        tt = 2'(t);
        if (v != 0) begin
            q_b.push_back({1'b1, tt, m_pc_b[t], mem_fn({tt, m_pc_b[t]})});
            m_pc_b[t] = m_pc_b[t] + 16'd1;
        end else begin
            q_b.push_back({1'b0, tt, m_pc_b[t], 16'hFFFF});
        end
    endtask

    // Synchronous-looking reset pulse used to start each scenario clean
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    // Outputs while reset is held from time zero
    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        total++;
        if (obs_rr !== {1'b0, 2'd0, 16'h0000, 16'hFFFF}) begin
            bad++;
            $display("[TB] FAIL reset_out_rr got %h expected %h", obs_rr, {1'b0, 2'd0, 16'h0000, 16'hFFFF});
        end
        total++;
        if (obs_b !== {1'b0, 2'd0, 16'h0000, 16'hFFFF}) begin
            bad++;
            $display("[TB] FAIL reset_out_b got %h expected %h", obs_b, {1'b0, 2'd0, 16'h0000, 16'hFFFF});
        end
        total++;
        if ({halted_rr, all_halted_rr, halted_b, all_halted_b} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL reset_halted got %b expected %b",
                     {halted_rr, all_halted_rr, halted_b, all_halted_b}, 10'b0);
        end
    endtask

    // No stalls: both modes walk threads 0..3 twice
    task automatic test_round_robin();
        int seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [34:0] exp_w;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            push_rr(1, seq[c]);
            push_b(1, seq[c]);
            @(posedge clk);
            #1;
            exp_w = q_rr.pop_front();
            total++;
            if (obs_rr !== exp_w) begin
                bad++;
                $display("[TB] FAIL rrobin_rr cycle %0d got %h expected %h", c, obs_rr, exp_w);
            end
            exp_w = q_b.pop_front();
            total++;
            if (obs_b !== exp_w) begin
                bad++;
                $display("[TB] FAIL rrobin_b cycle %0d got %h expected %h", c, obs_b, exp_w);
            end
        end
    endtask

    // Thread 1 held stalled: round-robin skips it, barrel issues bubbles
    task automatic test_stall();
        int rr_t[6] = '{0, 2, 3, 0, 2, 3};
        int b_v[6]  = '{1, 0, 1, 1, 1, 0};
        int b_t[6]  = '{0, 1, 2, 3, 0, 1};
        logic [34:0] exp_w;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            stall_req = 4'b0010;
            push_rr(1, rr_t[c]);
            push_b(b_v[c], b_t[c]);
            @(posedge clk);
            #1;
            exp_w = q_rr.pop_front();
            total++;
            if (obs_rr !== exp_w) begin
                bad++;
                $display("[TB] FAIL stall_rr cycle %0d got %h expected %h", c, obs_rr, exp_w);
            end
            exp_w = q_b.pop_front();
            total++;
            if (obs_b !== exp_w) begin
                bad++;
                $display("[TB] FAIL stall_b cycle %0d got %h expected %h", c, obs_b, exp_w);
            end
        end
        clear_inputs();
    endtask

    // Redirect of a stalled, non-selected thread, then a bypassed redirect
    // of the thread selected in the same cycle
    task automatic test_redirect();
        int seq[7] = '{0, 1, 2, 3, 0, 1, 2};
        logic [34:0] exp_w;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            clear_inputs();
            if (c == 0) begin
                stall_req      = 4'b1000;
                redirect_valid = 1'b1;
                redirect_tid   = 2'd3;
                redirect_pc    = 16'h0100;
                m_pc_rr[3]     = 16'h0100;
                m_pc_b[3]      = 16'h0100;
            end
            if (c == 2) begin
                redirect_valid = 1'b1;
                redirect_tid   = 2'd2;
                redirect_pc    = 16'h0040;
                m_pc_rr[2]     = 16'h0040;
                m_pc_b[2]      = 16'h0040;
            end
            push_rr(1, seq[c]);
            push_b(1, seq[c]);
            @(posedge clk);
            #1;
            exp_w = q_rr.pop_front();
            total++;
            if (obs_rr !== exp_w) begin
                bad++;
                $display("[TB] FAIL redirect_rr cycle %0d got %h expected %h", c, obs_rr, exp_w);
            end
            exp_w = q_b.pop_front();
            total++;
            if (obs_b !== exp_w) begin
                bad++;
                $display("[TB] FAIL redirect_b cycle %0d got %h expected %h", c, obs_b, exp_w);
            end
        end
        clear_inputs();
    endtask

    // Thread 1 redirected to the top of the address space wraps to zero
    task automatic test_pc_wrap();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        logic [34:0] exp_w;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            if (c == 0) begin
                redirect_valid = 1'b1;
                redirect_tid   = 2'd1;
                redirect_pc    = 16'hFFFF;
                m_pc_rr[1]     = 16'hFFFF;
                m_pc_b[1]      = 16'hFFFF;
            end
            push_rr(1, seq[c]);
            push_b(1, seq[c]);
            @(posedge clk);
            #1;
            exp_w = q_rr.pop_front();
            total++;
            if (obs_rr !== exp_w) begin
                bad++;
                $display("[TB] FAIL wrap_rr cycle %0d got %h expected %h", c, obs_rr, exp_w);
            end
            exp_w = q_b.pop_front();
            total++;
            if (obs_b !== exp_w) begin
                bad++;
                $display("[TB] FAIL wrap_b cycle %0d got %h expected %h", c, obs_b, exp_w);
            end
        end
        clear_inputs();
    endtask

    // Halt racing a redirect on thread 3, then halts of 2, 0 and 1 until
    // every slot is a bubble; a late redirect to a halted thread is ignored
    task automatic test_halt();
        int hv[11]  = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        int ht[11]  = '{3, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0};
        int rv[11]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int rt[11]  = '{3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int rp[11]  = '{'h200, 0, 0, 0, 0, 0, 0, 0, 'h300, 0, 0};
        int rrv[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int rrt[11] = '{0, 1, 2, 0, 1, 0, 1, 1, 1, 1, 1};
        int bv[11]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        int bt[11]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
        logic [34:0] exp_w;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            clear_inputs();
            halt_valid     = (hv[c] != 0);
            halt_tid       = 2'(ht[c]);
            redirect_valid = (rv[c] != 0);
            redirect_tid   = 2'(rt[c]);
            redirect_pc    = 16'(rp[c]);
            push_rr(rrv[c], rrt[c]);
            push_b(bv[c], bt[c]);
            @(posedge clk);
            #1;
            exp_w = q_rr.pop_front();
            total++;
            if (obs_rr !== exp_w) begin
                bad++;
                $display("[TB] FAIL halt_rr cycle %0d got %h expected %h", c, obs_rr, exp_w);
            end
            exp_w = q_b.pop_front();
            total++;
            if (obs_b !== exp_w) begin
                bad++;
                $display("[TB] FAIL halt_b cycle %0d got %h expected %h", c, obs_b, exp_w);
            end
            if (c == 0) begin
                total++;
                if ({halted_rr, all_halted_rr, halted_b, all_halted_b} !== 10'b1000_0_1000_0) begin
                    bad++;
                    $display("[TB] FAIL halt_first_flags got %b expected %b",
                             {halted_rr, all_halted_rr, halted_b, all_halted_b}, 10'b1000_0_1000_0);
                end
            end
        end
        total++;
        if ({halted_rr, all_halted_rr, halted_b, all_halted_b} !== 10'b1111_1_1111_1) begin
            bad++;
            $display("[TB] FAIL halt_all_flags got %b expected %b",
                     {halted_rr, all_halted_rr, halted_b, all_halted_b}, 10'b1111_1_1111_1);
        end
        clear_inputs();
    endtask

    // Short reset pulse between edges clears everything at once; fetch then
    // restarts from thread 0 at PC 0
    task automatic test_async_reset();
        int seq[4] = '{0, 1, 2, 3};
        logic [34:0] exp_w;
        clear_inputs();
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (obs_rr !== {1'b0, 2'd0, 16'h0000, 16'hFFFF}) begin
            bad++;
            $display("[TB] FAIL async_reset_rr got %h expected %h", obs_rr, {1'b0, 2'd0, 16'h0000, 16'hFFFF});
        end
        total++;
        if (obs_b !== {1'b0, 2'd0, 16'h0000, 16'hFFFF}) begin
            bad++;
            $display("[TB] FAIL async_reset_b got %h expected %h", obs_b, {1'b0, 2'd0, 16'h0000, 16'hFFFF});
        end
        total++;
        if ({halted_rr, all_halted_rr, halted_b, all_halted_b} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL async_reset_halted got %b expected %b",
                     {halted_rr, all_halted_rr, halted_b, all_halted_b}, 10'b0);
        end
        #1;
        reset = 1'b0;
        clear_model();
        for (int c = 0; c < 4; c++) begin
            push_rr(1, seq[c]);
            push_b(1, seq[c]);
            @(posedge clk);
            #1;
            exp_w = q_rr.pop_front();
            total++;
            if (obs_rr !== exp_w) begin
                bad++;
                $display("[TB] FAIL post_reset_rr cycle %0d got %h expected %h", c, obs_rr, exp_w);
            end
            exp_w = q_b.pop_front();
            total++;
            if (obs_b !== exp_w) begin
                bad++;
                $display("[TB] FAIL post_reset_b cycle %0d got %h expected %h", c, obs_b, exp_w);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_model();
        test_reset();
        test_round_robin();
        test_stall();
        test_redirect();
        test_pc_wrap();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
